button_debouncer: RTL and testbench

//  Cleans raw asynchronous board inputs (KEY/SW pins) before they reach the edge-detect stage.
//  Per channel: synchronizer, polarity normalisation, debounce FSM.
//  out[i] is a glitch-free, active-high level that feeds the posedge detector

---
 rtl/button_debouncer.sv | 96 +++++++++
 tb/tb_button_debouncer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: per-channel synchronizer, polarity normalisation and debounce FSM
// producing a glitch-free active-high level for a downstream edge detector.
module button_debouncer #(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;

    // Reset loads the released level so no phantom press appears after reset.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= {SYNC_STAGES{{WIDTH{ACTIVE_LOW}}}};
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end

    assign s = sync_q[SYNC_STAGES-1] ^ {WIDTH{ACTIVE_LOW}};

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : gen_ch
            state_t        state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= S_LOW;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    S_LOW: begin
                        if (s[g]) begin
                            state_d = S_RISE;
                            cnt_d   = CW'(1);
                        end
                    end
                    S_RISE: begin
                        if (!s[g]) begin
                            state_d = S_LOW;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_d = S_HIGH;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    S_HIGH: begin
                        if (!s[g]) begin
                            state_d = S_FALL;
                            cnt_d   = CW'(1);
                        end
                    end
                    S_FALL: begin
                        if (s[g]) begin
                            state_d = S_HIGH;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_MAX) begin
                            state_d = S_LOW;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign out[g]  = (state_q == S_HIGH) || (state_q == S_FALL);
            assign busy[g] = (state_q == S_RISE) || (state_q == S_FALL);
        end
    endgenerate
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed stimulus with a history-based reference model
// checked every cycle, plus hand-computed latency/rejection expectations.
module tb_button_debouncer;
    localparam int W  = 2;
    localparam int SS = 2;
    localparam int D  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] raw_in;
    logic [W-1:0] out;
    logic [W-1:0] busy;
    int           checks = 0;
    int           errors = 0;

    button_debouncer #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: s is raw_in delayed SS clocks and inverted; out flips once the last D
    // samples all disagree with it; busy means the latest sample disagrees with out.
    logic [SS-1:0][W-1:0] m_pipe;
    logic [W-1:0][D-1:0]  m_hist;
    logic [W-1:0]         m_out, m_busy;

    always @(posedge clk) begin : model
        logic         sv;
        logic [D-1:0] h;
        logic         o;
        if (reset) begin
            m_pipe <= '1;
            m_hist <= '0;
            m_out  <= '0;
            m_busy <= '0;
        end else begin
            m_pipe <= {m_pipe[SS-2:0], raw_in};
            for (int c = 0; c < W; c++) begin
                sv = ~m_pipe[SS-1][c];
                h  = {m_hist[c][D-2:0], sv};
                o  = (h == {D{~m_out[c]}}) ? ~m_out[c] : m_out[c];
                m_hist[c] <= h;
                m_out[c]  <= o;
                m_busy[c] <= sv ^ o;
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("model_out", out, m_out);
            chk("model_busy", busy, m_busy);
        end
    endtask

    logic [8:0] pat;

    initial begin
        reset  = 1'b1;
        raw_in = 2'b11;
        tick(2);
        reset = 1'b0;
        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("t1_out", out, 2'b00);
            chk("t1_busy", busy, 2'b00);
        end
        // 2: clean press and release on channel 0
        raw_in[0] = 1'b0;
        tick(2);
        chk1("t2_busy_early", busy[0], 1'b0);
        tick(1);
        chk1("t2_busy_3", busy[0], 1'b1);
        chk1("t2_out_3", out[0], 1'b0);
        tick(2);
        chk1("t2_out_5", out[0], 1'b0);
        tick(1);
        chk1("t2_out_6", out[0], 1'b1);
        chk1("t2_busy_6", busy[0], 1'b0);
        raw_in[0] = 1'b1;
        tick(5);
        chk1("t2_rel_5", out[0], 1'b1);
        tick(1);
        chk1("t2_rel_6", out[0], 1'b0);
        tick(4);
        // 3: bounce 0,1,0,0,1,0,0,0,0 then held low
        pat = 9'b000010010;
        for (int j = 0; j < 9; j++) begin
            raw_in[0] = pat[j];
            tick(1);
            chk1("t3_no_pulse", out[0], 1'b0);
        end
        tick(1);
        chk1("t3_out_9", out[0], 1'b0);
        tick(1);
        chk1("t3_out_10", out[0], 1'b1);
        raw_in[0] = 1'b1;
        tick(8);
        chk("t3_released", out, 2'b00);
        // 4: 3-clock glitch on channel 1
        raw_in[1] = 1'b0;
        tick(3);
        raw_in[1] = 1'b1;
        chk1("t4_busy_on", busy[1], 1'b1);
        chk1("t4_out_on", out[1], 1'b0);
        tick(3);
        chk1("t4_busy_off", busy[1], 1'b0);
        chk1("t4_out_off", out[1], 1'b0);
        tick(4);
        chk("t4_idle_out", out, 2'b00);
        chk("t4_idle_busy", busy, 2'b00);
        // 5: simultaneous press, channel 1 bounces once
        raw_in = 2'b00;
        tick(1);
        raw_in[1] = 1'b1;
        tick(1);
        raw_in[1] = 1'b0;
        tick(3);
        chk("t5_out_5", out, 2'b00);
        tick(1);
        chk("t5_out_6", out, 2'b01);
        tick(1);
        chk("t5_out_7", out, 2'b01);
        tick(1);
        chk("t5_out_8", out, 2'b11);
        raw_in = 2'b11;
        tick(8);
        chk("t5_released", out, 2'b00);
        // 6: reset during qualification of channel 0
        raw_in[0] = 1'b0;
        tick(4);
        chk1("t6_busy_pre", busy[0], 1'b1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_out_rst", out, 2'b00);
        chk("t6_busy_rst", busy, 2'b00);
        tick(2);
        chk1("t6_busy_2", busy[0], 1'b0);
        tick(1);
        chk1("t6_busy_3", busy[0], 1'b1);
        tick(2);
        chk1("t6_out_5", out[0], 1'b0);
        tick(1);
        chk1("t6_out_6", out[0], 1'b1);
        raw_in = 2'b11;
        tick(8);
        chk("t6_released", out, 2'b00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
